// File: rtl/button_event_decoder.sv
// button_event_decoder
//   Turns a clean, debounced active-high button level into one-cycle user
//   events: press, release, click, double-click and long-press. A build-time
//   option adds auto-repeat ticks while the button is held long.
//
//   Build option: define BTN_REPEAT_EN to enable auto-repeat in the long-hold
//   state. Without it, repeat_o is tied low.
//
//   Ports:
//     clk_i      in   system clock, rising edge
//     rst_i      in   synchronous active-high reset
//     level_i    in   debounced button level, 1 = pressed
//     press_o    out  1-cycle pulse on each press
//     release_o  out  1-cycle pulse on each release
//     click_o    out  1-cycle pulse, single click confirmed
//     dclick_o   out  1-cycle pulse, double click
//     long_o     out  1-cycle pulse, long-press threshold reached
//     repeat_o   out  1-cycle pulse, auto-repeat tick
//     held_o     out  level, high while in the long-hold state
module button_event_decoder #(
  parameter int unsigned LONG_CYCLES   = 1000,
  parameter int unsigned DCLICK_CYCLES = 300,
  parameter int unsigned REPEAT_CYCLES = 200,
  parameter int unsigned CNT_W         = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic level_i,
  output logic press_o,
  output logic release_o,
  output logic click_o,
  output logic dclick_o,
  output logic long_o,
  output logic repeat_o,
  output logic held_o
);

  localparam longint unsigned CNT_LIM = 64'(1) << CNT_W;

  // Reject thresholds the shared counter cannot reach.
  if (LONG_CYCLES < 2 || 64'(LONG_CYCLES) >= CNT_LIM ||
      DCLICK_CYCLES < 2 || 64'(DCLICK_CYCLES) >= CNT_LIM ||
      REPEAT_CYCLES < 2 || 64'(REPEAT_CYCLES) >= CNT_LIM) begin : g_bad_param
    $error("button_event_decoder: *_CYCLES must be >= 2 and < 2**CNT_W");
  end

  localparam logic [CNT_W-1:0] LONG_MAX   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] DCLICK_MAX = CNT_W'(DCLICK_CYCLES - 1);
`ifdef BTN_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_MAX = CNT_W'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    PRESSED     = 3'd1,
    WAIT_SECOND = 3'd2,
    PRESSED2    = 3'd3,
    LONG_HELD   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q;
  logic             rise, fall;
  logic             press_d, release_d, click_d, dclick_d, long_d, held_d;
`ifdef BTN_REPEAT_EN
  logic             repeat_d;
`endif

  assign rise = level_i & ~level_q;
  assign fall = ~level_i & level_q;

  // State, counter, edge history and registered event outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
      click_o   <= 1'b0;
      dclick_o  <= 1'b0;
      long_o    <= 1'b0;
      held_o    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_i;
      press_o   <= press_d;
      release_o <= release_d;
      click_o   <= click_d;
      dclick_o  <= dclick_d;
      long_o    <= long_d;
      held_o    <= held_d;
    end
  end

`ifdef BTN_REPEAT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      repeat_o <= 1'b0;
    end else begin
      repeat_o <= repeat_d;
    end
  end
`else
  assign repeat_o = 1'b0;
`endif

  // Next state and event decode; edges always take priority over thresholds.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    press_d   = 1'b0;
    release_d = 1'b0;
    click_d   = 1'b0;
    dclick_d  = 1'b0;
    long_d    = 1'b0;
`ifdef BTN_REPEAT_EN
    repeat_d  = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rise) begin
          press_d = 1'b1;
          state_d = PRESSED;
        end
      end
      PRESSED: begin
        if (fall) begin
          release_d = 1'b1;
          state_d   = WAIT_SECOND;
        end else if (cnt_q == LONG_MAX) begin
          long_d  = 1'b1;
          state_d = LONG_HELD;
        end
      end
      WAIT_SECOND: begin
        if (rise) begin
          press_d = 1'b1;
          state_d = PRESSED2;
        end else if (cnt_q == DCLICK_MAX) begin
          click_d = 1'b1;
          state_d = IDLE;
        end
      end
      PRESSED2: begin
        if (fall) begin
          release_d = 1'b1;
          dclick_d  = 1'b1;
          state_d   = IDLE;
        end else if (cnt_q == LONG_MAX) begin
          // The first tap is still owed its click.
          click_d = 1'b1;
          long_d  = 1'b1;
          state_d = LONG_HELD;
        end
      end
      LONG_HELD: begin
`ifdef BTN_REPEAT_EN
        if (fall) begin
          release_d = 1'b1;
          state_d   = IDLE;
        end else if (cnt_q == REPEAT_MAX) begin
          repeat_d = 1'b1;
          cnt_d    = '0;
        end
`else
        cnt_d = '0;
        if (fall) begin
          release_d = 1'b1;
          state_d   = IDLE;
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end
    held_d = (state_d == LONG_HELD);
  end

endmodule

// File: tb/tb_button_event_decoder.sv
module tb_button_event_decoder;

  localparam int unsigned LONG_C = 8;
  localparam int unsigned DCL_C  = 5;
  localparam int unsigned REP_C  = 3;
`ifdef BTN_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_i;
  logic level_i;
  logic press_o, release_o, click_o, dclick_o, long_o, repeat_o, held_o;

  button_event_decoder #(
    .LONG_CYCLES  (LONG_C),
    .DCLICK_CYCLES(DCL_C),
    .REPEAT_CYCLES(REP_C),
    .CNT_W        (16)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .level_i  (level_i),
    .press_o  (press_o),
    .release_o(release_o),
    .click_o  (click_o),
    .dclick_o (dclick_o),
    .long_o   (long_o),
    .repeat_o (repeat_o),
    .held_o   (held_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Output vector order: {press, release, click, dclick, long, repeat, held}
  localparam logic [6:0] E_NONE  = 7'b0000000;
  localparam logic [6:0] E_PRESS = 7'b1000000;
  localparam logic [6:0] E_REL   = 7'b0100000;
  localparam logic [6:0] E_CLICK = 7'b0010000;

  typedef struct {
    logic       rst;
    logic       lvl;
    logic [6:0] exp;
  } vec_t;
  vec_t tab[13];

  // Reference model: tracks taps, whether the hold went long, the level last
  // seen, and the edge number at which the current interval started.
  int   now, mark, taps;
  bit   is_long, prev;
  logic [6:0] m_exp;

  // Pulse tallies for sequence-level checks.
  int t_press, t_rel, t_click, t_dclick, t_long, t_rep;

  task automatic model_step(input logic r, input logic l);
    int el;
    bit rise, fall;
    m_exp = '0;
    now++;
    if (r) begin
      prev = 0; taps = 0; is_long = 0; mark = now;
      return;
    end
    rise = l & ~prev;
    fall = ~l & prev;
    el   = now - mark;
    if (rise) begin
      if (taps < 2) begin
        m_exp[6] = 1'b1;
        taps++;
        mark = now;
      end
    end else if (fall) begin
      m_exp[5] = 1'b1;
      if (is_long) begin
        is_long = 0; taps = 0;
      end else if (taps == 2) begin
        m_exp[3] = 1'b1;
        taps = 0;
      end else begin
        mark = now;
      end
    end else if (prev && !is_long && el == int'(LONG_C)) begin
      m_exp[2] = 1'b1;
      if (taps == 2) m_exp[4] = 1'b1;
      is_long = 1;
      mark = now;
    end else if (!prev && taps == 1 && el == int'(DCL_C)) begin
      m_exp[4] = 1'b1;
      taps = 0;
    end else if (is_long && REP_ON && el == int'(REP_C)) begin
      m_exp[1] = 1'b1;
      mark = now;
    end
    prev = l;
    m_exp[0] = is_long;
  endtask

  task automatic step(input string name, input logic r, input logic l,
                      input bit use_tab, input logic [6:0] tab_exp);
    logic [6:0] act, exp;
    rst_i   = r;
    level_i = l;
    @(posedge clk_i);
    model_step(r, l);
    #1;
    act = {press_o, release_o, click_o, dclick_o, long_o, repeat_o, held_o};
    exp = use_tab ? tab_exp : m_exp;
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: outputs got %b expected %b", name, $time, act, exp);
    end
    t_press  += int'(press_o);
    t_rel    += int'(release_o);
    t_click  += int'(click_o);
    t_dclick += int'(dclick_o);
    t_long   += int'(long_o);
    t_rep    += int'(repeat_o);
  endtask

  task automatic run(input string name, input logic l, input int n);
    for (int i = 0; i < n; i++) step(name, 1'b0, l, 1'b0, E_NONE);
  endtask

  task automatic clr_tally();
    t_press = 0; t_rel = 0; t_click = 0; t_dclick = 0; t_long = 0; t_rep = 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: count got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    // Reset then a single click: 3 high, then low until the click confirms.
    tab[0]  = '{1'b1, 1'b0, E_NONE};
    tab[1]  = '{1'b1, 1'b0, E_NONE};
    tab[2]  = '{1'b1, 1'b0, E_NONE};
    tab[3]  = '{1'b0, 1'b1, E_PRESS};
    tab[4]  = '{1'b0, 1'b1, E_NONE};
    tab[5]  = '{1'b0, 1'b1, E_NONE};
    tab[6]  = '{1'b0, 1'b0, E_REL};
    tab[7]  = '{1'b0, 1'b0, E_NONE};
    tab[8]  = '{1'b0, 1'b0, E_NONE};
    tab[9]  = '{1'b0, 1'b0, E_NONE};
    tab[10] = '{1'b0, 1'b0, E_NONE};
    tab[11] = '{1'b0, 1'b0, E_CLICK};
    tab[12] = '{1'b0, 1'b0, E_NONE};

    now = 0; mark = 0; taps = 0; is_long = 0; prev = 0;
    rst_i = 1'b1; level_i = 1'b0;
    clr_tally();

    // Idle after reset: no pulses for 20 cycles.
    for (int i = 0; i < 3; i++) step("reset", 1'b1, 1'b0, 1'b1, E_NONE);
    for (int i = 0; i < 20; i++) step("idle", 1'b0, 1'b0, 1'b1, E_NONE);

    for (int i = 0; i < 13; i++) step("click_vec", tab[i].rst, tab[i].lvl, 1'b1, tab[i].exp);

    // Double click.
    clr_tally();
    run("dclick", 1'b1, 3); run("dclick", 1'b0, 2);
    run("dclick", 1'b1, 3); run("dclick", 1'b0, 10);
    chk("dclick_press", t_press, 2);
    chk("dclick_rel", t_rel, 2);
    chk("dclick_pulse", t_dclick, 1);
    chk("dclick_noclick", t_click, 0);

    // Long press: fall lands on a repeat tick, which is suppressed.
    clr_tally();
    run("long", 1'b1, 20); run("long", 1'b0, 4);
    chk("long_pulse", t_long, 1);
    chk("long_rep", t_rep, REP_ON ? 3 : 0);
    chk("long_noclick", t_click, 0);
    chk("long_rel", t_rel, 1);

    // Reset during the wait for a second press.
    clr_tally();
    run("rst_wait", 1'b1, 3); run("rst_wait", 1'b0, 2);
    step("rst_wait", 1'b1, 1'b0, 1'b0, E_NONE);
    step("rst_wait", 1'b1, 1'b0, 1'b0, E_NONE);
    run("rst_wait", 1'b0, 12);
    chk("rst_wait_noclick", t_click, 0);

    // Fall on the same cycle the long threshold would be reached.
    clr_tally();
    run("tie", 1'b1, int'(LONG_C)); run("tie", 1'b0, 10);
    chk("tie_nolong", t_long, 0);
    chk("tie_rel", t_rel, 1);
    chk("tie_click", t_click, 1);

    // Triple tap then an immediate long hold on level high after reset.
    clr_tally();
    for (int k = 0; k < 3; k++) begin run("triple", 1'b1, 2); run("triple", 1'b0, 2); end
    run("triple", 1'b0, 10);
    chk("triple_dclick", t_dclick, 1);
    chk("triple_click", t_click, 1);
    step("rst_hi", 1'b1, 1'b1, 1'b0, E_NONE);
    step("rst_hi", 1'b0, 1'b1, 1'b1, E_PRESS);

    // Tap then long hold on the second press.
    run("tap_long", 1'b0, 2); run("tap_long", 1'b1, 2);
    run("tap_long", 1'b0, 2); run("tap_long", 1'b1, 14); run("tap_long", 1'b0, 8);

    // Randomized runs against the model.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 39) == 0) begin
        step("rand_rst", 1'b1, 1'($urandom_range(0, 1)), 1'b0, E_NONE);
      end
      run("rand", 1'($urandom_range(0, 1)), int'($urandom_range(1, 12)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
